// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, runs the req/ack handshake to instruction
// memory and feeds the IF/ID slot. Optional perf counters are enabled by defining PERF_CNT_EN.
module if_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        IFID_write,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] PC,
  output logic [15:0] PC_Plus1,
  output logic [15:0] Inst,
  output logic        valid
`ifdef PERF_CNT_EN
  ,
  output logic [15:0] fetch_cnt,
  output logic [15:0] bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_REDIR = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] fpc_q, fpc_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] inst_q, inst_d;
  logic        valid_q, valid_d;
  logic        pend_q, pend_d;
  logic        req_s;
  logic        xfer_s;
  logic        consume_s;
  logic        slot_free_s;

  assign consume_s   = valid_q & ~IFID_write;
  assign slot_free_s = ~valid_q | ~IFID_write;

  // State register and IF/ID output slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RST;
      fpc_q   <= RESET_PC;
      pc_q    <= RESET_PC;
      inst_q  <= 16'h0000;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state, handshake and slot update.
  // A pending request always implies an empty slot, because req only rises when the
  // slot is free or being consumed, so an acknowledged transfer always has a home.
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    pend_d  = pend_q;
    req_s   = 1'b0;
    xfer_s  = 1'b0;
    case (state_q)
      ST_RST: begin
        state_d = ST_FETCH;
        pend_d  = 1'b0;
      end
      ST_FETCH: begin
        req_s = slot_free_s | pend_q;
        if (redirect_en) begin
          // Redirect beats stall; any data acknowledged on this edge is dropped.
          state_d = ST_REDIR;
          valid_d = 1'b0;
          fpc_d   = redirect_pc;
          pend_d  = 1'b0;
        end else begin
          xfer_s = req_s & imem_ack & slot_free_s;
          pend_d = req_s & ~imem_ack;
          if (xfer_s) begin
            fpc_d   = fpc_q + 16'd1;
            pc_d    = fpc_q;
            inst_d  = imem_rdata;
            valid_d = 1'b1;
          end else if (consume_s) begin
            valid_d = 1'b0;
          end else begin
            valid_d = valid_q;
          end
        end
      end
      ST_REDIR: begin
        valid_d = 1'b0;
        pend_d  = 1'b0;
        if (redirect_en) begin
          state_d = ST_REDIR;
          fpc_d   = redirect_pc;
        end else begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_RST;
        valid_d = 1'b0;
        pend_d  = 1'b0;
      end
    endcase
  end

  assign imem_req  = req_s;
  assign imem_addr = fpc_q;
  assign PC        = pc_q;
  assign PC_Plus1  = pc_q + 16'd1;
  assign Inst      = inst_q;
  assign valid     = valid_q;

`ifdef PERF_CNT_EN
  logic [15:0] fetch_cnt_q;
  logic [15:0] bubble_cnt_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    if (en && (v != 16'hFFFF)) begin
      return v + 16'd1;
    end else begin
      return v;
    end
  endfunction

  // Saturating transfer and bubble counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_cnt_q  <= 16'h0000;
      bubble_cnt_q <= 16'h0000;
    end else begin
      fetch_cnt_q  <= sat_inc(fetch_cnt_q, xfer_s);
      bubble_cnt_q <= sat_inc(bubble_cnt_q, ~IFID_write & ~valid_q);
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
